// File: rtl/variable_pkg.sv
// -----------------------------------------------------------------------------
// variable_pkg
// Shared game constants and types.
//   PLAYER_1 / PLAYER_2 : encodings of the active-player flag (turn)
//   MIN_SPEED/MAX_SPEED : launch speed range produced by the charge meter
//   Y_ON_MAX            : largest on-screen projectile y (pixels)
//   throw_state_t       : launch controller states
// -----------------------------------------------------------------------------
package variable_pkg;

   localparam logic PLAYER_1 = 1'b0;
   localparam logic PLAYER_2 = 1'b1;

   localparam logic [4:0] MIN_SPEED = 5'd4;
   localparam logic [4:0] MAX_SPEED = 5'd31;

   localparam logic [11:0] Y_ON_MAX = 12'd767;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHARGE = 3'd1,
      LAUNCH = 3'd2,
      FLIGHT = 3'd3,
      SETTLE = 3'd4
   } throw_state_t;

endpackage

// File: rtl/throw_ctl_btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// Two-flop synchronizer for an asynchronous button level, followed by an
// edge register producing one-cycle rise/fall pulses.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   btn   in  raw button level (asynchronous)
//   rise  out one-cycle pulse on a synchronized 0->1 transition
//   fall  out one-cycle pulse on a synchronized 1->0 transition
// A pin change becomes visible on rise/fall 2-3 cycles later. A pulse that
// starts and ends between two clock edges is never sampled, so it yields
// no edge.
// -----------------------------------------------------------------------------
module btn_sync
   import variable_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= btn;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: rtl/throw_ctl.sv
// -----------------------------------------------------------------------------
// throw_ctl
// Player-side launch controller feeding the projectile simulator.
// Charges launch power while fire is held, emits a one-cycle throw_flag with
// the latched speed on release, generates the vertical trajectory during
// flight in step with the simulator's x stepping, and hands the turn over
// when the simulator reports end_throw.
//   clk60MHz      in   system clock
//   rst           in   asynchronous active-high reset
//   btn_fire      in   raw fire button level
//   end_throw     in   one-cycle pulse: throw resolved (honoured in FLIGHT only)
//   throw_flag    out  one-cycle launch pulse
//   speed         out  launch speed, frozen from throw_flag until end_throw
//   ypos_prebuff  out  projectile y in pixels (Y_OFF when not in flight)
//   turn          out  active player
//   charging      out  high while charging
// -----------------------------------------------------------------------------
module throw_ctl
   import variable_pkg::*;
#(
   parameter int TICK_PERIOD   = 100001,
   parameter int CHARGE_DIV    = 6_000_000,
   parameter int SETTLE_CYCLES = 30_000_000,
   parameter int Y_START       = 300,
   parameter int Y_OFF         = 768
)(
   input  logic        clk60MHz,
   input  logic        rst,
   input  logic        btn_fire,
   input  logic        end_throw,
   output logic        throw_flag,
   output logic [4:0]  speed,
   output logic [11:0] ypos_prebuff,
   output logic        turn,
   output logic        charging
);

   localparam int TW = $clog2(TICK_PERIOD + 1);
   localparam int CW = $clog2(CHARGE_DIV + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_PERIOD - 1);
   localparam logic [CW-1:0] CHARGE_LAST = CW'(CHARGE_DIV - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [11:0]   Y_START_12  = 12'(Y_START);
   localparam logic [11:0]   Y_OFF_12    = 12'(Y_OFF);

   throw_state_t r_state;
   throw_state_t w_state_next;

   logic              w_rise;
   logic              w_fall;
   logic [4:0]        r_speed;
   logic [CW-1:0]     r_charge_cnt;
   logic [TW-1:0]     r_tick_cnt;
   logic [SW-1:0]     r_settle_cnt;
   logic [11:0]       r_ypos;
   logic signed [6:0] r_vy;
   logic              r_turn;

   logic              w_throw_flag;
   logic              w_charging;
   logic              w_tick;
   logic signed [12:0] w_y_sum;
   logic [11:0]       w_y_clamped;
   logic signed [6:0] w_vy_inc;
   logic signed [6:0] w_vy_launch;

   btn_sync u_btn_sync (
      .clk  (clk60MHz),
      .rst  (rst),
      .btn  (btn_fire),
      .rise (w_rise),
      .fall (w_fall)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk60MHz or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_throw_flag = 1'b0;
      w_charging   = 1'b0;
      case (r_state)
         IDLE:   if (w_rise) w_state_next = CHARGE;
         CHARGE: begin
            w_charging = 1'b1;
            if (w_fall) w_state_next = LAUNCH;
         end
         LAUNCH: begin
            w_throw_flag = 1'b1;
            w_state_next = FLIGHT;
         end
         FLIGHT: if (end_throw) w_state_next = SETTLE;
         // Only a fresh rise in IDLE starts a charge, so a button held
         // through SETTLE never auto-fires.
         SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------- trajectory arithmetic ----------------
   assign w_tick      = (r_tick_cnt == TICK_LAST);
   assign w_y_sum     = $signed({1'b0, r_ypos}) + 13'(r_vy);
   assign w_vy_inc    = (r_vy == 7'sd63) ? 7'sd63 : r_vy + 7'sd1;
   assign w_vy_launch = -$signed({2'b00, r_speed});

   always_comb begin
      w_y_clamped = w_y_sum[11:0];
      if (w_y_sum < 13'sd0)
         w_y_clamped = 12'd0;
      else if (w_y_sum > $signed({1'b0, Y_ON_MAX}))
         w_y_clamped = Y_ON_MAX;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk60MHz or posedge rst) begin
      if (rst) begin
         r_speed      <= MIN_SPEED;
         r_charge_cnt <= '0;
         r_tick_cnt   <= '0;
         r_settle_cnt <= '0;
         r_ypos       <= Y_OFF_12;
         r_vy         <= '0;
         r_turn       <= PLAYER_1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_speed      <= MIN_SPEED;
                  r_charge_cnt <= '0;
               end
            end
            CHARGE: begin
               if (r_charge_cnt == CHARGE_LAST) begin
                  r_charge_cnt <= '0;
                  if (r_speed != MAX_SPEED) r_speed <= r_speed + 5'd1;
               end else begin
                  r_charge_cnt <= r_charge_cnt + 1'b1;
               end
               // Load the launch height as LAUNCH is entered so it is
               // already valid while throw_flag is high.
               if (w_fall) r_ypos <= Y_START_12;
            end
            LAUNCH: begin
               r_vy         <= w_vy_launch;
               r_tick_cnt   <= '0;
               r_settle_cnt <= '0;
            end
            FLIGHT: begin
               // end_throw wins over a coincident step.
               if (end_throw) begin
                  r_ypos     <= Y_OFF_12;
                  r_turn     <= (r_turn == PLAYER_1) ? PLAYER_2 : PLAYER_1;
                  r_tick_cnt <= '0;
               end else if (w_tick) begin
                  r_tick_cnt <= '0;
                  r_ypos     <= w_y_clamped;
                  r_vy       <= w_vy_inc;
               end else begin
                  r_tick_cnt <= r_tick_cnt + 1'b1;
               end
            end
            SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign throw_flag   = w_throw_flag;
   assign charging     = w_charging;
   assign speed        = r_speed;
   assign ypos_prebuff = r_ypos;
   assign turn         = r_turn;

endmodule

// File: tb/tb_throw_ctl.sv
// -----------------------------------------------------------------------------
// tb_throw_ctl
// Directed bench for throw_ctl. Two instances share all inputs: one launches
// from y=300, the other from y=20 to exercise the clamp at 0.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, so a value read after step() reflects that edge.
// -----------------------------------------------------------------------------
module tb_throw_ctl;
   import variable_pkg::*;

   logic        clk60MHz = 1'b0;
   logic        rst;
   logic        btn_fire;
   logic        end_throw;
   logic        throw_flag,   throw_flag_b;
   logic [4:0]  speed,        speed_b;
   logic [11:0] ypos_prebuff, ypos_prebuff_b;
   logic        turn,         turn_b;
   logic        charging,     charging_b;

   int n_chk = 0;
   int n_err = 0;
   int k;
   int exp_speed;

   always #5 clk60MHz = ~clk60MHz;

   throw_ctl #(.TICK_PERIOD(5), .CHARGE_DIV(10), .SETTLE_CYCLES(20),
               .Y_START(300), .Y_OFF(768)) dut (
      .clk60MHz(clk60MHz), .rst(rst), .btn_fire(btn_fire), .end_throw(end_throw),
      .throw_flag(throw_flag), .speed(speed), .ypos_prebuff(ypos_prebuff),
      .turn(turn), .charging(charging));

   throw_ctl #(.TICK_PERIOD(5), .CHARGE_DIV(10), .SETTLE_CYCLES(20),
               .Y_START(20), .Y_OFF(768)) dut_low (
      .clk60MHz(clk60MHz), .rst(rst), .btn_fire(btn_fire), .end_throw(end_throw),
      .throw_flag(throw_flag_b), .speed(speed_b), .ypos_prebuff(ypos_prebuff_b),
      .turn(turn_b), .charging(charging_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk60MHz);
      #1;
   endtask

   // Steps until throw_flag is seen (bounded); returns edges taken.
   task automatic wait_flag(output int edges);
      edges = 0;
      while (edges < 10) begin
         step();
         edges++;
         if (throw_flag) break;
      end
   endtask

   initial begin
      rst = 1'b1; btn_fire = 1'b0; end_throw = 1'b0;
      #1;
      chk("rst_y",        ypos_prebuff, 768);
      chk("rst_speed",    speed,        4);
      chk("rst_turn",     turn,         PLAYER_1);
      chk("rst_flag",     throw_flag,   0);
      chk("rst_charging", charging,     0);
      repeat (3) step();
      rst = 1'b0;
      step(); step();
      $display("reset released");

      // Glitch between two edges: never sampled.
      btn_fire = 1'b1; #2; btn_fire = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("glitch_no_charge", charging, 0);
      end
      $display("glitch pulse applied");

      // Throw A: release after 65 edges -> speed 10.
      btn_fire = 1'b1;
      for (int n = 1; n <= 65; n++) begin
         step();
         if (n == 3) chk("charge_not_yet", charging, 0);
         if (n == 4) begin
            chk("charge_enter", charging, 1);
            chk("charge_min_speed", speed, 4);
         end
      end
      chk("speed_at_release", speed, 10);
      btn_fire = 1'b0;
      wait_flag(k);
      chk("release_to_flag", k, 4);
      chk("launch_speed", speed, 10);
      chk("launch_y", ypos_prebuff, 300);
      chk("launch_y_low", ypos_prebuff_b, 20);
      step();
      chk("flag_one_cycle", throw_flag, 0);
      for (int m = 2; m <= 16; m++) begin
         step();
         if (m == 5)  chk("y_before_step", ypos_prebuff, 300);
         if (m == 6)  begin chk("y_step1", ypos_prebuff, 290); chk("y_low_step1", ypos_prebuff_b, 10); end
         if (m == 11) begin chk("y_step2", ypos_prebuff, 281); chk("y_low_step2", ypos_prebuff_b, 1); end
         if (m == 16) begin chk("y_step3", ypos_prebuff, 273); chk("y_low_clamp", ypos_prebuff_b, 0); end
      end
      chk("speed_frozen", speed, 10);
      end_throw = 1'b1;
      step();
      end_throw = 1'b0;
      chk("end_y_off", ypos_prebuff, 768);
      chk("end_turn", turn, PLAYER_2);
      $display("throw A done");

      // Press during SETTLE and hold it past the end of SETTLE.
      btn_fire = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         chk("settle_held_no_charge", charging, 0);
      end
      btn_fire = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("after_release_idle", charging, 0);
      $display("held button through settle");

      // Spurious end_throw in IDLE.
      end_throw = 1'b1; step(); end_throw = 1'b0; step();
      chk("spurious_idle_turn", turn, PLAYER_2);
      chk("spurious_idle_state", charging, 0);
      chk("spurious_idle_flag", throw_flag, 0);
      $display("spurious end_throw in idle");

      // Throw B: long hold, speed saturates at 31; spurious end_throw in CHARGE.
      btn_fire = 1'b1;
      for (int n = 1; n <= 320; n++) begin
         step();
         if (n == 50) end_throw = 1'b1;
         if (n == 51) end_throw = 1'b0;
         if (n >= 4) begin
            exp_speed = 4 + (n - 4) / 10;
            if (exp_speed > 31) exp_speed = 31;
            chk("charge_speed", speed, exp_speed);
         end
      end
      chk("spurious_charge_turn", turn, PLAYER_2);
      chk("spurious_charge_state", charging, 1);
      btn_fire = 1'b0;
      wait_flag(k);
      chk("release_to_flag_b", k, 4);
      chk("launch_speed_sat", speed, 31);
      chk("launch_y_b", ypos_prebuff, 300);
      chk("launch_y_low_b", ypos_prebuff_b, 20);
      for (int m = 1; m <= 15; m++) begin
         step();
         if (m == 1)  chk("single_flag", throw_flag, 0);
         if (m == 6)  begin chk("y31_step1", ypos_prebuff, 269); chk("y_low31_step1", ypos_prebuff_b, 0); end
         if (m == 11) begin chk("y31_step2", ypos_prebuff, 239); chk("y_low31_step2", ypos_prebuff_b, 0); end
      end
      // end_throw lands on a step edge: Y_OFF must win.
      end_throw = 1'b1;
      step();
      end_throw = 1'b0;
      chk("coincide_y_off", ypos_prebuff, 768);
      chk("coincide_y_off_low", ypos_prebuff_b, 768);
      chk("coincide_turn", turn, PLAYER_1);
      for (int i = 0; i < 25; i++) step();
      $display("throw B done");

      // Throw C: speed 5, end early -> turn back to PLAYER_2.
      btn_fire = 1'b1;
      for (int n = 1; n <= 10; n++) step();
      btn_fire = 1'b0;
      wait_flag(k);
      chk("launch_speed_c", speed, 5);
      for (int m = 1; m <= 6; m++) step();
      chk("y_c_step1", ypos_prebuff, 295);
      end_throw = 1'b1; step(); end_throw = 1'b0;
      chk("turn_c", turn, PLAYER_2);
      for (int i = 0; i < 25; i++) step();
      $display("throw C done");

      // Throw D: reset mid-flight.
      btn_fire = 1'b1;
      for (int n = 1; n <= 10; n++) step();
      btn_fire = 1'b0;
      wait_flag(k);
      for (int m = 1; m <= 6; m++) step();
      chk("y_d_step1", ypos_prebuff, 295);
      #2 rst = 1'b1;
      #1;
      chk("midflight_rst_y", ypos_prebuff, 768);
      chk("midflight_rst_turn", turn, PLAYER_1);
      chk("midflight_rst_flag", throw_flag, 0);
      chk("midflight_rst_speed", speed, 4);
      chk("midflight_rst_charging", charging, 0);
      step(); step();
      rst = 1'b0;
      step();
      btn_fire = 1'b1;
      for (int n = 1; n <= 5; n++) step();
      chk("post_rst_idle_charge", charging, 1);
      btn_fire = 1'b0;
      $display("reset mid-flight done");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/throw_ctl.md
# throw_ctl

Player-side launch controller that drives the projectile simulator. It charges launch power while the fire button is held and emits a one-cycle `throw_flag` with the latched `speed` on release. During flight it generates the vertical trajectory `ypos_prebuff` in lock-step with the simulator's horizontal stepping. It toggles `turn` when the simulator reports `end_throw`. It sits between the input/debounce logic and `simulate`, at the 60 MHz game clock.

## Interface
Parameters:
- `TICK_PERIOD`, 100001: cycles per trajectory step; must equal the simulator's x-step period.
- `CHARGE_DIV`, 6_000_000: cycles per speed increment while charging (0.1 s).
- `SETTLE_CYCLES`, 30_000_000: hold-off after a throw before a new charge is accepted (0.5 s).
- `Y_START`, 300: launch height in pixels.
- `Y_OFF`, 768: off-screen y while no projectile is in flight.

Ports (one clock; reset is asynchronous and active-high):
- `clk60MHz`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_fire`  in  1  raw fire button, level, asynchronous to `clk60MHz`.
- `end_throw`  in  1  one-cycle pulse from the simulator: the throw has resolved.
- `throw_flag`  out  1  one-cycle launch pulse to the simulator.
- `speed`  out  5  launch speed; stable from `throw_flag` until `end_throw`.
- `ypos_prebuff`  out  12  projectile y in pixels, unsigned, range 0..768.
- `turn`  out  1  active player (`PLAYER_1` / `PLAYER_2`).
- `charging`  out  1  high in CHARGE, for the power-bar display.

## Operation
- Reset values: `throw_flag`=0, `speed`=`MIN_SPEED` (4), `ypos_prebuff`=`Y_OFF`, `turn`=`PLAYER_1`, `charging`=0, state IDLE, all counters 0.
- IDLE:
  - A rising edge on the synchronized button goes to CHARGE.
  - On that transition `speed`=`MIN_SPEED` and the charge counter is cleared.
- CHARGE:
  - `charging`=1.
  - The charge counter counts to `CHARGE_DIV`-1, then wraps to 0 and `speed` increments.
  - `speed` saturates at 31 and never wraps.
  - A falling edge on the synchronized button goes to LAUNCH.
- LAUNCH (exactly one cycle):
  - `throw_flag`=1, `ypos_prebuff`=`Y_START`.
  - Internal vy = −`speed` (signed 7-bit); tick counter cleared.
  - Next state is FLIGHT.
- FLIGHT:
  - The tick counter increments every cycle.
  - When it equals `TICK_PERIOD`-1 it clears and a step is applied: y_next = y + vy, then vy_next = vy + 1.
  - vy saturates at +63.
  - y is computed 13-bit signed and clamped to 0..767 before driving `ypos_prebuff`.
  - On `end_throw`=1 go to SETTLE, set `ypos_prebuff`=`Y_OFF` and toggle `turn`, all in the same cycle.
- SETTLE:
  - Count `SETTLE_CYCLES`, then go to IDLE.
  - If the button is still held at that point, IDLE requires a fresh rising edge, so a held button never auto-fires.
- `end_throw` is ignored outside FLIGHT. Button edges are ignored in LAUNCH, FLIGHT and SETTLE.
- A button rise and fall within the same sample (glitch shorter than the synchronizer) produces no edge and no action.

## Timing
- Button path: two-flop synchronizer plus edge register. An edge is seen 2–3 cycles after the pin changes.
- Release to `throw_flag`: 1 cycle after the falling-edge detect (CHARGE→LAUNCH registered).
- Signals changing on the `throw_flag` cycle:
  - `ypos_prebuff`=`Y_START` on the same cycle, so the simulator's registered y is valid on its first THROW cycle.
  - `speed` is frozen from that cycle onward.
- The first y step occurs `TICK_PERIOD` cycles after LAUNCH, aligned with the simulator's first x step (±1 cycle).
- `end_throw` to `turn` toggle: the next rising edge.
- Reset mid-operation (any state): all outputs return to reset values asynchronously. A `throw_flag` in progress is dropped.
- If `end_throw` coincides with a tick, the tick is discarded and `Y_OFF` wins.

## Structure
- Add to `variable_pkg`:
  - `MIN_SPEED`=4, `MAX_SPEED`=31.
  - State enum `throw_state_t` {IDLE, CHARGE, LAUNCH, FLIGHT, SETTLE}.
- Reuse the existing `PLAYER_1`/`PLAYER_2` from `variable_pkg`.
- Sub-module `btn_sync`: two-flop synchronizer with registered `rise`/`fall` pulses, with async active-high reset.
- Top-level `throw_ctl` contains the FSM, charge counter, tick counter, and y/vy datapath.

## Test plan
- Reset:
  - Assert `rst` mid-FLIGHT → `ypos_prebuff`=768, `turn`=`PLAYER_1`, `throw_flag`=0 immediately.
  - After release → IDLE.
- Charge saturation:
  - Hold the button 4 s (CHARGE_DIV reduced to 10 in sim) → `speed` goes 4,5,…,31 and stays at 31.
  - Release → single `throw_flag` with `speed`=31.
- Trajectory:
  - `speed`=10, TICK_PERIOD=5 → y sequence 300, 290, 281, 273, … (vy −10, −9, −8, …) on every 5th cycle.
  - Verify the clamp at 0 with `speed`=31, `Y_START`=20.
- End of throw:
  - Pulse `end_throw` in FLIGHT → next cycle `ypos_prebuff`=768 and `turn` toggled.
  - Button press during SETTLE → no CHARGE.
- Held button:
  - Keep the button high through SETTLE → no new throw until release and re-press.
- Spurious `end_throw`:
  - Pulse it in IDLE and CHARGE → `turn` unchanged, state unchanged.
